// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types and constants for the load/store unit.
//   lsu_state_e : controller FSM states
//   F3_*        : RISC-V funct3 size/sign codes for loads/stores
//   req_err()   : illegal-funct3 / misalignment check done at accept
package lsu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int NUM_LANES = 4;  // byte lanes per memory word

  // Unsigned variants (1xx) exist only for loads.
  function automatic logic req_err(input logic we, input logic [2:0] f3,
                                   input logic [1:0] a);
    logic ill, mis;
    ill = (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
    mis = ((f3[1:0] == 2'b01) && a[0]) ||
          ((f3[1:0] == 2'b10) && (a != 2'b00));
    return ill || mis;
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: word-organised data memory bus.
//   master : LSU side (drives enable/write-enable/address/write-data)
//   slave  : memory side (returns read word one cycle after the address)
interface lsu_ctrl_if #(
  parameter int ADDR_W = 14
);
  logic              o_mem_enb;
  logic              o_mem_wren;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [31:0]       o_mem_wdata;
  logic [31:0]       i_mem_rdata;

  modport master (output o_mem_enb, o_mem_wren, o_mem_addr, o_mem_wdata,
                  input  i_mem_rdata);
  modport slave  (input  o_mem_enb, o_mem_wren, o_mem_addr, o_mem_wdata,
                  output i_mem_rdata);
endinterface

// File: rtl/lsu_align.sv
// lsu_align: combinational data alignment.
//   word    : memory word just read
//   lane    : byte address bits [1:0]
//   funct3  : size/sign code
//   wdata   : store data (rs2)
//   ld_data : extracted, sign/zero-extended load result
//   st_word : word with the addressed byte/halfword replaced by wdata
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);
  logic [7:0]  b;
  logic [15:0] h;

  assign b = word[{lane, 3'b000} +: 8];
  assign h = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    ld_data = '0;
    case (funct3)
      F3_B:    ld_data = {{24{b[7]}}, b};
      F3_BU:   ld_data = {24'd0, b};
      F3_H:    ld_data = {{16{h[15]}}, h};
      F3_HU:   ld_data = {16'd0, h};
      F3_W:    ld_data = word;
      default: ld_data = '0;
    endcase
  end

  // Each lane picks either the old byte or the matching byte of wdata.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    localparam logic [1:0] LN = 2'(i);
    logic       sel;
    logic [7:0] src;
    always_comb begin
      sel = 1'b1;
      src = wdata[8*i +: 8];
      case (funct3[1:0])
        2'b00: begin sel = (lane == LN);       src = wdata[7:0];          end
        2'b01: begin sel = (lane[1] == LN[1]); src = wdata[8*(i%2) +: 8]; end
        default: ;
      endcase
    end
    assign st_word[8*i +: 8] = sel ? src : word[8*i +: 8];
  end

endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding RISC-V load/store unit.
//   i_clk, i_rst           : clock, synchronous active-high reset
//   i_req/i_we/i_funct3    : request strobe (sampled in IDLE), store flag, size code
//   i_addr, i_wdata        : byte address, store data
//   o_rdata/o_done/o_err   : load result, completion pulse, error flag
//   o_busy                 : high while not IDLE
//   mem                    : data memory bus (master side)
// Sub-word stores are read-modify-write since memory writes whole words.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_err,
  output logic        o_busy,
  lsu_ctrl_if.master  mem
);
  // Read latency is fixed at one cycle; RD_WAIT assumes that.
  localparam int unused_rd_lat = RD_LAT;

  lsu_state_e        state, nxt;
  logic              we_q, err_q;
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W-1:0] addr_r;
  logic [31:0]       mwd_r;
  logic [31:0]       ld_data, st_word;
  logic              acc, acc_err;
  logic              unused_addr;

  assign unused_addr = ^i_addr[31:ADDR_W];
  assign acc         = (state == IDLE) && i_req;
  assign acc_err     = req_err(i_we, i_funct3, i_addr[1:0]);

  lsu_align u_align (
    .word    (mem.i_mem_rdata),
    .lane    (lane_q),
    .funct3  (f3_q),
    .wdata   (wdata_q),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (i_req) nxt = acc_err ? DONE :
                                (i_we && i_funct3 == F3_W) ? WR : RD;
      RD:      nxt = RD_WAIT;
      RD_WAIT: nxt = we_q ? WR : DONE;
      WR:      nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Gating with ~i_rst keeps a reset cycle from issuing a half-done RMW write.
  always_comb begin
    mem.o_mem_enb  = ~i_rst && (state == RD || state == WR);
    mem.o_mem_wren = ~i_rst && (state == WR);
    o_done         = (state == DONE);
    o_err          = (state == DONE) && err_q;
    o_busy         = (state != IDLE);
  end

  assign mem.o_mem_addr  = addr_r;
  assign mem.o_mem_wdata = mwd_r;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      addr_r  <= '0;
      mwd_r   <= '0;
      o_rdata <= '0;
    end else begin
      if (acc) begin
        we_q    <= i_we;
        err_q   <= acc_err;
        f3_q    <= i_funct3;
        lane_q  <= i_addr[1:0];
        wdata_q <= i_wdata;
        if (acc_err) o_rdata <= '0;
        else         addr_r  <= {i_addr[ADDR_W-1:2], 2'b00};
        if (!acc_err && i_we && i_funct3 == F3_W) mwd_r <= i_wdata;
      end
      if (state == RD_WAIT) begin
        if (we_q) mwd_r   <= st_word;
        else      o_rdata <= ld_data;
      end
      if (state == WR) o_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int AW = 14;

  logic        clk = 1'b0;
  logic        rst, req, we;
  logic [2:0]  f3;
  logic [31:0] addr, wdata, rdata;
  logic        done, err, busy;

  lsu_ctrl_if #(.ADDR_W(AW)) mif ();

  lsu_ctrl #(.ADDR_W(AW), .RD_LAT(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_funct3(f3),
    .i_addr(addr), .i_wdata(wdata), .o_rdata(rdata), .o_done(done),
    .o_err(err), .o_busy(busy), .mem(mif.master)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, read-before-write on the same word.
  logic [31:0]   mem [0:(1<<(AW-2))-1];
  int            rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [31:0]   last_wdata = '0;

  always @(posedge clk) begin
    if (mif.o_mem_enb) begin
      if (mif.o_mem_wren) begin
        mem[mif.o_mem_addr[AW-1:2]] <= mif.o_mem_wdata;
        wr_cnt     <= wr_cnt + 1;
        last_waddr <= mif.o_mem_addr;
        last_wdata <= mif.o_mem_wdata;
      end else begin
        rd_cnt <= rd_cnt + 1;
      end
      mif.i_mem_rdata <= mem[mif.o_mem_addr[AW-1:2]];
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  int pass_cnt = 0, chk_cnt = 0;

  // Called at a negedge in IDLE; returns at the negedge of the IDLE cycle after DONE.
  task automatic run_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output logic [31:0] rd,
                         output logic e, output logic enb1, output logic wren1);
    req = 1'b1; we = w; f3 = f; addr = a; wdata = d;
    @(negedge clk);
    req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
    enb1 = mif.o_mem_enb; wren1 = mif.o_mem_wren; lat = 1;
    while (!done && lat < 20) begin @(negedge clk); lat++; end
    rd = rdata; e = err;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk_cnt++; if ({done, err, busy} !== 3'b000) $display("FAIL reset_flags got %b exp 000", {done, err, busy}); else pass_cnt++;
    chk_cnt++; if (rdata !== 32'h0) $display("FAIL reset_rdata got %h exp 0", rdata); else pass_cnt++;
    chk_cnt++; if ({mif.o_mem_enb, mif.o_mem_wren} !== 2'b00) $display("FAIL reset_enb got %b exp 00", {mif.o_mem_enb, mif.o_mem_wren}); else pass_cnt++;
    chk_cnt++; if (mif.o_mem_addr !== '0 || mif.o_mem_wdata !== 32'h0) $display("FAIL reset_bus got %h/%h exp 0/0", mif.o_mem_addr, mif.o_mem_wdata); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sw_lw_b2b();
    int lat; logic [31:0] r; logic e, en1, wr1; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    run_req(1'b1, F3_W, 32'h40, 32'h8899AABB, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 2 || !en1 || !wr1) $display("FAIL sw_lat got lat=%0d enb=%b wren=%b exp 2/1/1", lat, en1, wr1); else pass_cnt++;
    chk_cnt++; if (last_waddr !== 14'h40 || last_wdata !== 32'h8899AABB || wr_cnt - w0 != 1 || rd_cnt != r0) $display("FAIL sw_write got %h %h w=%0d r=%0d exp 40 8899aabb 1 0", last_waddr, last_wdata, wr_cnt - w0, rd_cnt - r0); else pass_cnt++;
    run_req(1'b1, F3_W, 32'h100, 32'hDEADBEEF, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 2 || r !== 32'h0 || e !== 1'b0) $display("FAIL sw2 got lat=%0d r=%h e=%b exp 2 0 0", lat, r, e); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL b2b_idle busy got %b exp 0", busy); else pass_cnt++;
    run_req(1'b0, F3_W, 32'h100, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 3 || r !== 32'hDEADBEEF || e !== 1'b0) $display("FAIL b2b_lw got lat=%0d r=%h e=%b exp 3 deadbeef 0", lat, r, e); else pass_cnt++;
  endtask

  task automatic test_loads();
    int lat; logic [31:0] r; logic e, en1, wr1;
    run_req(1'b0, F3_B, 32'h43, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 3 || r !== 32'hFFFFFF88 || e !== 1'b0 || !en1 || wr1) $display("FAIL lb got lat=%0d r=%h e=%b exp 3 ffffff88 0", lat, r, e); else pass_cnt++;
    run_req(1'b0, F3_BU, 32'h43, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (r !== 32'h00000088) $display("FAIL lbu got %h exp 00000088", r); else pass_cnt++;
    run_req(1'b0, F3_H, 32'h42, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (r !== 32'hFFFF8899) $display("FAIL lh got %h exp ffff8899", r); else pass_cnt++;
    run_req(1'b0, F3_HU, 32'h40, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (r !== 32'h0000AABB) $display("FAIL lhu got %h exp 0000aabb", r); else pass_cnt++;
    run_req(1'b0, F3_B, 32'hFFFF0041, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (r !== 32'hFFFFFFAA || e !== 1'b0) $display("FAIL lb_hiaddr got %h e=%b exp ffffffaa 0", r, e); else pass_cnt++;
  endtask

  task automatic test_rmw();
    int lat; logic [31:0] r; logic e, en1, wr1; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    run_req(1'b1, F3_B, 32'h41, 32'h12345677, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 4 || r !== 32'h0 || e !== 1'b0) $display("FAIL sb_lat got lat=%0d r=%h e=%b exp 4 0 0", lat, r, e); else pass_cnt++;
    chk_cnt++; if (rd_cnt - r0 != 1 || wr_cnt - w0 != 1) $display("FAIL sb_txn got rd=%0d wr=%0d exp 1 1", rd_cnt - r0, wr_cnt - w0); else pass_cnt++;
    chk_cnt++; if (last_waddr !== 14'h40 || last_wdata !== 32'h889977BB) $display("FAIL sb_merge got %h %h exp 40 889977bb", last_waddr, last_wdata); else pass_cnt++;
    run_req(1'b1, F3_H, 32'h42, 32'h5555CAFE, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 4 || last_wdata !== 32'hCAFE77BB) $display("FAIL sh_merge got lat=%0d %h exp 4 cafe77bb", lat, last_wdata); else pass_cnt++;
  endtask

  task automatic test_errors();
    int lat; logic [31:0] r; logic e, en1, wr1; int w0, r0;
    w0 = wr_cnt; r0 = rd_cnt;
    run_req(1'b0, F3_H, 32'h101, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 1 || e !== 1'b1 || r !== 32'h0 || en1) $display("FAIL err_lh got lat=%0d e=%b r=%h enb=%b exp 1 1 0 0", lat, e, r, en1); else pass_cnt++;
    run_req(1'b1, F3_W, 32'h102, 32'h11111111, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 1 || e !== 1'b1 || en1) $display("FAIL err_sw got lat=%0d e=%b enb=%b exp 1 1 0", lat, e, en1); else pass_cnt++;
    run_req(1'b0, 3'b110, 32'h100, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 1 || e !== 1'b1) $display("FAIL err_f3_110 got lat=%0d e=%b exp 1 1", lat, e); else pass_cnt++;
    run_req(1'b1, F3_BU, 32'h100, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (lat != 1 || e !== 1'b1) $display("FAIL err_sbu got lat=%0d e=%b exp 1 1", lat, e); else pass_cnt++;
    chk_cnt++; if (rd_cnt != r0 || wr_cnt != w0) $display("FAIL err_nomem got rd=%0d wr=%0d exp 0 0", rd_cnt - r0, wr_cnt - w0); else pass_cnt++;
  endtask

  task automatic test_rst_mid_rmw();
    int lat, n; logic [31:0] r; logic e, en1, wr1; int w0;
    w0 = wr_cnt;
    req = 1'b1; we = 1'b1; f3 = F3_H; addr = 32'h40; wdata = 32'h00001234;
    @(negedge clk);
    req = 1'b0; we = 1'b0; f3 = '0; addr = '0; wdata = '0;
    n = 0;
    while (!mif.o_mem_wren && n < 10) begin @(negedge clk); n++; end
    chk_cnt++; if (mif.o_mem_wren !== 1'b1) $display("FAIL rst_reach_wr got wren=%b exp 1", mif.o_mem_wren); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if ({mif.o_mem_enb, mif.o_mem_wren} !== 2'b00) $display("FAIL rst_gate got %b exp 00", {mif.o_mem_enb, mif.o_mem_wren}); else pass_cnt++;
    @(negedge clk);
    chk_cnt++; if ({busy, done, err, mif.o_mem_enb, mif.o_mem_wren} !== 5'b0 || rdata !== 32'h0 || mif.o_mem_addr !== '0 || mif.o_mem_wdata !== 32'h0) $display("FAIL rst_outs got b=%b d=%b e=%b r=%h a=%h w=%h exp all 0", busy, done, err, rdata, mif.o_mem_addr, mif.o_mem_wdata); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    chk_cnt++; if (wr_cnt != w0) $display("FAIL rst_nowrite got %0d exp 0", wr_cnt - w0); else pass_cnt++;
    run_req(1'b0, F3_W, 32'h40, 32'h0, lat, r, e, en1, wr1);
    chk_cnt++; if (r !== 32'hCAFE77BB) $display("FAIL rst_mem got %h exp cafe77bb", r); else pass_cnt++;
  endtask

  task automatic test_ignore_req();
    int d0, r0, w0;
    d0 = done_cnt; r0 = rd_cnt; w0 = wr_cnt;
    req = 1'b1; we = 1'b0; f3 = F3_W; addr = 32'h100; wdata = 32'h0;
    @(negedge clk);
    req = 1'b1; we = 1'b1; f3 = F3_W; addr = 32'h200; wdata = 32'h01020304;
    @(negedge clk);
    @(negedge clk);
    chk_cnt++; if (done !== 1'b1 || rdata !== 32'hDEADBEEF) $display("FAIL ign_done got d=%b r=%h exp 1 deadbeef", done, rdata); else pass_cnt++;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (4) @(negedge clk);
    chk_cnt++; if (busy !== 1'b0 || done_cnt - d0 != 1 || rd_cnt - r0 != 1 || wr_cnt != w0) $display("FAIL ign_count got busy=%b done=%0d rd=%0d wr=%0d exp 0 1 1 0", busy, done_cnt - d0, rd_cnt - r0, wr_cnt - w0); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sw_lw_b2b();
    test_loads();
    test_rmw();
    test_errors();
    test_rst_mid_rmw();
    test_ignore_req();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit sitting between the core's execute stage and the word-organised data memory.
- Accepts one RISC-V load/store request at a time: LB/LH/LW/LBU/LHU/SB/SH/SW.
- Drives the memory's enable/write-enable/address/write-data and consumes its read data.
- Memory writes whole words only, so SB/SH are done as read-modify-write. Loads are extracted and sign/zero-extended back to the core.

Parameters:
- ADDR_W, 14, byte-address width presented to data memory. Word index is addr[ADDR_W-1:2].
- RD_LAT, 1, cycles from memory address/enable to valid i_mem_rdata. Fixed at 1 for this revision.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset, synchronous, active-high
- i_req  in  1  request strobe, sampled only in IDLE
- i_we  in  1  1=store, 0=load
- i_funct3  in  3  RISC-V funct3 size/sign code
- i_addr  in  32  byte address; bits [ADDR_W-1:0] used
- i_wdata  in  32  store data (rs2)
- o_rdata  out  32  extended load result, valid when o_done=1
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  with o_done: misaligned or illegal funct3
- o_busy  out  1  high whenever state != IDLE
- o_mem_enb  out  1  memory enable
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  ADDR_W  byte address to memory
- o_mem_wdata  out  32  word to write
- i_mem_rdata  in  32  memory read word, valid RD_LAT cycles after address

Behaviour:
- Reset: state=IDLE. o_rdata=0, o_done=0, o_err=0, o_busy=0, o_mem_enb=0, o_mem_wren=0, o_mem_addr=0, o_mem_wdata=0.
- o_mem_enb and o_mem_wren are gated with ~i_rst, so no write issues during a reset cycle, even mid-RMW.
- Request capture:
  - In IDLE with i_req=1, latch we, funct3, addr[ADDR_W-1:0] and wdata.
  - i_req is ignored in all other states. No queueing.
- Error check at accept:
  - Illegal funct3: 011, 110, 111; for stores also 100 and 101.
  - Misaligned: H with addr[0]=1; W with addr[1:0]!=0.
  - On error: IDLE -> DONE with o_err=1, o_rdata=0, and no memory access at all.
- States: IDLE, RD, RD_WAIT, WR, DONE.
  - LW/LH/LB/LHU/LBU: IDLE -> RD -> RD_WAIT -> DONE.
  - SW: IDLE -> WR -> DONE.
  - SB/SH: IDLE -> RD -> RD_WAIT -> WR -> DONE.
  - DONE -> IDLE unconditionally.
- Memory drive by state:
  - RD: o_mem_enb=1, o_mem_wren=0, o_mem_addr={addr[ADDR_W-1:2],2'b00}.
  - WR: o_mem_enb=1, o_mem_wren=1, same address.
  - Otherwise enb=wren=0. Address/wdata hold their last value.
- Latency from the accept edge T to o_done=1: error T+1; SW T+2; loads T+3; SB/SH T+4. Back-to-back: the next request is accepted in the cycle after DONE.
- Read word: captured at the end of RD_WAIT into a register.
- Load extraction:
  - Byte lane = addr[1:0]; halfword = addr[1].
  - LB/LH sign-extend from bit 7/15. LBU/LHU zero-extend. LW passes through.
  - o_rdata is registered and valid in DONE.
  - o_rdata holds its value until the next DONE. On store completion it is cleared to 0.
- Store merge:
  - SB replaces byte lane addr[1:0] of the read word with wdata[7:0].
  - SH replaces halfword addr[1] with wdata[15:0].
  - SW writes wdata unchanged.
- Address bits above ADDR_W-1 are ignored. No range error is raised.
- o_done and o_err are high only in DONE.
- Reset asserted in any state returns to IDLE on that edge. A pending o_done is dropped.

Decomposition:
- lsu_pkg holds:
  - state enum lsu_state_e (IDLE, RD, RD_WAIT, WR, DONE);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- One combinational sub-module, lsu_align, contains:
  - load extraction: word + lane + funct3 -> 32-bit result;
  - store merge: word + lane + funct3 + wdata -> merged word.

Test Plan:
- Memory word 0x40 = 0x8899AABB; LB addr 0x43 -> o_done at T+3, o_rdata=0xFFFFFF88, o_err=0. LBU same address -> 0x00000088.
- SB addr 0x41 wdata=0x12345677 over word 0x8899AABB -> one RD then one WR at byte addr 0x40 with o_mem_wdata=0x889977BB. o_done at T+4.
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> write at T+1, done T+2. Next request accepted the cycle after DONE returns 0xDEADBEEF.
- LH addr 0x101 and SW addr 0x102 -> o_done with o_err=1 at T+1, o_mem_enb never asserted. Also funct3=110 load gives o_err=1.
- Assert i_rst in WR of an SH -> o_mem_wren=0 in that cycle, memory unchanged, o_busy=0 and all outputs zero the next cycle.
- Pulse i_req while o_busy=1 -> ignored: exactly one DONE and one memory transaction per accepted request.
